// File: rtl/imem_loader.sv
// Instruction memory with base-address translation, fault flagging and a
// handshake program loader. Define IMEM_SYNC_READ_EN for a registered fetch path.
module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h00400000,
  parameter logic [31:0] NOP_WORD  = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              imem_raddr,
  output logic [31:0]              imem_rdata,
  output logic                     imem_fault,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic                     load_last,
  input  logic [31:0]              load_data,
  output logic                     load_ready,
  output logic                     load_done,
  output logic [$clog2(DEPTH):0]   load_count,
  output logic                     cpu_hold
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [31:0]   DEPTH32  = 32'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_LOAD
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic          accept;
  logic          last_beat;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   idx;
  logic          fetch_fault;
  logic [31:0]   fetch_data;
  logic          fetch_fault_out;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (load_start)            state_nxt = S_LOAD;
      S_LOAD: if (accept && last_beat)   state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    load_ready = 1'b0;
    cpu_hold   = 1'b0;
    if (state == S_LOAD) begin
      load_ready = 1'b1;
      cpu_hold   = 1'b1;
    end
  end

  assign accept    = load_ready & load_valid;
  // Closing at the last slot keeps overflow words from ever being written.
  assign last_beat = load_last | (ptr == LAST_PTR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      load_count <= '0;
      load_done  <= 1'b0;
    end else begin
      load_done <= accept & last_beat;
      if (state == S_IDLE && load_start) begin
        ptr        <= '0;
        load_count <= '0;
      end else if (accept) begin
        ptr        <= ptr + 1'b1;
        load_count <= load_count + 1'b1;
      end
    end
  end

  // Array deliberately has no reset so programs survive rst.
  always_ff @(posedge clk) begin
    if (accept) mem[ptr] <= load_data;
  end

  always_comb begin
    idx             = (imem_raddr - BASE_ADDR) >> 2;
    fetch_fault     = (imem_raddr[1:0] != 2'b00) || (imem_raddr < BASE_ADDR) || (idx >= DEPTH32);
    fetch_data      = NOP_WORD;
    fetch_fault_out = 1'b0;
    if (!cpu_hold) begin
      if (fetch_fault) fetch_fault_out = 1'b1;
      else             fetch_data      = mem[idx[AW-1:0]];
    end
  end

`ifdef IMEM_SYNC_READ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_rdata <= NOP_WORD;
      imem_fault <= 1'b0;
    end else begin
      imem_rdata <= fetch_data;
      imem_fault <= fetch_fault_out;
    end
  end
`else
  assign imem_rdata = fetch_data;
  assign imem_fault = fetch_fault_out;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a DEPTH=1024 and a DEPTH=4
// instance checked against an associative-array program model.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h00400000;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr, ldata;
  logic        lvalid, llast, ls_a, ls_b;

  logic [31:0] rdata_a, rdata_b;
  logic        fault_a, ready_a, done_a, hold_a;
  logic        fault_b, ready_b, done_b, hold_b;
  logic [10:0] count_a;
  logic [2:0]  count_b;

  imem_loader dut_a (
    .clk(clk), .rst(rst), .imem_raddr(raddr), .imem_rdata(rdata_a), .imem_fault(fault_a),
    .load_start(ls_a), .load_valid(lvalid), .load_last(llast), .load_data(ldata),
    .load_ready(ready_a), .load_done(done_a), .load_count(count_a), .cpu_hold(hold_a)
  );

  imem_loader #(.DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .imem_raddr(raddr), .imem_rdata(rdata_b), .imem_fault(fault_b),
    .load_start(ls_b), .load_valid(lvalid), .load_last(llast), .load_data(ldata),
    .load_ready(ready_b), .load_done(done_b), .load_count(count_b), .cpu_hold(hold_b)
  );

  always #5 clk = ~clk;

  int unsigned cmp = 0;
  int unsigned bad = 0;

  // Model: written words per instance, session flag, write pointer, counts.
  logic [31:0] mdl_a [int unsigned];
  logic [31:0] mdl_b [int unsigned];
  bit          sel;
  bit          m_load;
  int unsigned m_ptr;
  int unsigned m_cnt [2];

  logic [31:0] o_rdata;
  logic        o_fault, o_ready, o_done, o_hold;
  int unsigned o_cnt;
  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_fault = sel ? fault_b : fault_a;
  assign o_ready = sel ? ready_b : ready_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_hold  = sel ? hold_b  : hold_a;
  assign o_cnt   = sel ? 32'(count_b) : 32'(count_a);

  function automatic int unsigned depth_of();
    return sel ? 4 : 1024;
  endfunction

  // One clock cycle of loader stimulus with checks before and after the edge.
  task automatic beat(input bit st, input bit v, input bit l, input logic [31:0] d);
    bit exp_done;
    ls_a = st && !sel; ls_b = st && sel;
    lvalid = v; llast = l; ldata = d;
    #2;
    cmp++; if (o_ready !== m_load) begin bad++; $display("FAIL load_ready: got %0b want %0b", o_ready, m_load); end
    cmp++; if (o_hold !== m_load) begin bad++; $display("FAIL cpu_hold: got %0b want %0b", o_hold, m_load); end
    cmp++; if (o_cnt !== m_cnt[sel]) begin bad++; $display("FAIL load_count: got %0d want %0d", o_cnt, m_cnt[sel]); end
    exp_done = 1'b0;
    if (!m_load) begin
      if (st) begin m_load = 1'b1; m_ptr = 0; m_cnt[sel] = 0; end
    end else if (v) begin
      if (sel) mdl_b[m_ptr] = d; else mdl_a[m_ptr] = d;
      m_cnt[sel]++;
      if (l || m_ptr == depth_of() - 1) begin m_load = 1'b0; exp_done = 1'b1; end
      m_ptr++;
    end
    @(posedge clk); #1;
    ls_a = 1'b0; ls_b = 1'b0; lvalid = 1'b0; llast = 1'b0;
    cmp++; if (o_done !== exp_done) begin bad++; $display("FAIL load_done: got %0b want %0b", o_done, exp_done); end
  endtask

  task automatic check_fetch(input logic [31:0] a);
    logic [31:0] ed;
    bit          ef, known;
    int unsigned key;
    known = 1'b0; ed = NOP; ef = 1'b0;
    if (!m_load) begin
      ef = (a % 4 != 0) || (a < BASE) || (longint'(a) >= longint'(BASE) + 4 * longint'(depth_of()));
      if (!ef) begin
        key   = (a - BASE) / 4;
        known = sel ? mdl_b.exists(key) : mdl_a.exists(key);
        if (known) ed = sel ? mdl_b[key] : mdl_a[key];
      end
    end
    raddr = a; lvalid = 1'b0;
`ifdef IMEM_SYNC_READ_EN
    @(posedge clk); #1;
`else
    #2;
`endif
    cmp++; if (o_fault !== ef) begin bad++; $display("FAIL imem_fault @%h: got %0b want %0b", a, o_fault, ef); end
    if (ef || m_load || known) begin
      cmp++; if (o_rdata !== ed) begin bad++; $display("FAIL imem_rdata @%h: got %h want %h", a, o_rdata, ed); end
    end
`ifndef IMEM_SYNC_READ_EN
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset();
    bit exp_f;
`ifdef IMEM_SYNC_READ_EN
    exp_f = 1'b0;
`else
    exp_f = 1'b1;
`endif
    rst = 1'b1; raddr = '0; ldata = '0; lvalid = 0; llast = 0; ls_a = 0; ls_b = 0;
    #2;
    cmp++; if ({ready_a, hold_a, done_a, ready_b, hold_b, done_b} !== 6'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 000000", {ready_a, hold_a, done_a, ready_b, hold_b, done_b}); end
    cmp++; if (count_a !== 11'd0 || count_b !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d/%0d want 0/0", count_a, count_b); end
    cmp++; if (rdata_a !== NOP) begin bad++; $display("FAIL reset_rdata: got %h want %h", rdata_a, NOP); end
    cmp++; if (fault_a !== exp_f) begin bad++; $display("FAIL reset_fault: got %0b want %0b", fault_a, exp_f); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_load = 1'b0; m_ptr = 0; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic test_load_basic();
    logic [31:0] w [4];
    w[0] = 32'h00500093; w[1] = 32'h00100113; w[2] = 32'h002081B3; w[3] = 32'h00000013;
    sel = 1'b0;
    beat(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) beat(0, 1, i == 3, w[i]);
    beat(0, 1, 0, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) check_fetch(BASE + 32'(4 * i));
  endtask

  task automatic test_fault();
    sel = 1'b0;
    check_fetch(32'h00400002);
    check_fetch(32'h003FFFFC);
    check_fetch(BASE + 32'h1000);
    check_fetch(BASE + 32'h0FFC);
    check_fetch(32'hFFFFFFFC);
    for (int i = 0; i < 20; i++) check_fetch(BASE - 32'd64 + $urandom_range(0, 4096 + 128));
  endtask

  task automatic test_random_load();
    int unsigned n, i;
    bit v;
    sel = 1'b0;
    n = $urandom_range(1, 24);
    beat(1, 0, 0, '0);
    i = 0;
    while (i < n) begin
      v = ($urandom_range(0, 3) != 0);
      beat(0, v, v && (i == n - 1), $urandom);
      if (v) i++;
    end
    beat(0, 0, 0, '0);
    for (int k = 0; k < int'(n) + 2; k++) check_fetch(BASE + 32'(4 * k));
  endtask

  task automatic test_hold();
    sel = 1'b0;
    beat(1, 0, 0, '0);
    beat(0, 1, 0, $urandom);
    beat(0, 1, 0, $urandom);
    check_fetch(BASE + 32'd4);
    beat(1, 0, 0, '0);
    beat(0, 1, 1, $urandom);
    beat(0, 0, 0, '0);
    check_fetch(BASE + 32'd8);
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    check_fetch(32'h00400010);
    beat(1, 0, 0, '0);
    for (int i = 0; i < 6; i++) beat(0, 1, 0, $urandom);
    beat(0, 0, 0, '0);
    for (int i = 0; i < 5; i++) check_fetch(BASE + 32'(4 * i));
  endtask

  task automatic test_rst_mid();
    sel = 1'b1;
    beat(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) beat(0, 1, i == 3, $urandom);
    beat(1, 0, 0, '0);
    beat(0, 1, 0, $urandom);
    beat(0, 1, 0, $urandom);
    rst = 1'b1;
    #2;
    m_load = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
    cmp++; if ({ready_b, hold_b, done_b} !== 3'b000) begin bad++; $display("FAIL rst_mid_ctrl: got %b want 000", {ready_b, hold_b, done_b}); end
    cmp++; if (count_b !== 3'd0) begin bad++; $display("FAIL rst_mid_count: got %0d want 0", count_b); end
    @(posedge clk); #1;
    rst = 1'b0;
    cmp++; if (done_b !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %0b want 0", done_b); end
    for (int i = 0; i < 4; i++) check_fetch(BASE + 32'(4 * i));
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int s = 0; s < 3; s++) begin
      beat(1, 0, 0, '0);
      for (int i = 0; i < 3; i++) beat(0, 1, i == 2, $urandom);
    end
    for (int i = 0; i < 6; i++) check_fetch(BASE + 32'(4 * $urandom_range(0, 4)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; m_load = 1'b0; m_ptr = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    test_reset();
    test_load_basic();
    test_fault();
    test_random_load();
    test_hold();
    test_overflow();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
